// File: rtl/iccm_boot_loader.sv
// Boot loader: assembles a UART byte stream (length header, data words, checksum)
// into ICCM writes while holding the core in reset; reports status and errors.
module iccm_boot_loader #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned LEN_BYTES   = 2,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_i,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W:0]   words_o
);

    localparam int unsigned LEN_W = 8 * LEN_BYTES;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDone, StErr} state_t;

    state_t            r_state;
    logic              r_prog;
    logic [LEN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_len_words;
    logic [2:0]        r_byte_cnt;
    logic [DATA_W-1:0] r_word;
    logic [7:0]        r_csum;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_core_rst_n;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [CNT_W-1:0]  r_words;

    logic              w_prog_rise;
    logic              w_active;
    logic [LEN_W-1:0]  w_len_next;
    logic [DATA_W-1:0] w_word_next;
    logic              w_len_last;
    logic              w_len_bad;
    logic              w_word_last;
    logic [CNT_W-1:0]  w_idx_next;
    logic              w_last_word;
    logic              w_tmo_exp;
    logic              w_fail;
    logic [1:0]        w_fail_code;

    assign w_prog_rise = prog_i & ~r_prog;
    assign w_active    = (r_state == StLen) || (r_state == StData) || (r_state == StCsum);
    // Accumulators are cleared at start/word boundaries, so OR-ing places bytes LSB first.
    assign w_len_next  = r_len | (LEN_W'(rx_byte_i) << {r_byte_cnt, 3'b000});
    assign w_word_next = r_word | (DATA_W'(rx_byte_i) << {r_byte_cnt, 3'b000});
    assign w_len_last  = (r_byte_cnt == 3'(LEN_BYTES - 1));
    assign w_len_bad   = (w_len_next == '0) || (32'(w_len_next) > DEPTH);
    assign w_word_last = (r_byte_cnt == 3'(DATA_W / 8 - 1));
    assign w_idx_next  = r_words + CNT_W'(1);
    assign w_last_word = (w_idx_next == r_len_words);
    assign w_tmo_exp   = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    // Abort beats a byte, and a byte beats a simultaneous timeout expiry.
    always_comb begin
        w_fail      = 1'b0;
        w_fail_code = 2'd0;
        if (w_active) begin
            if (!prog_i) begin
                w_fail      = 1'b1;
                w_fail_code = 2'd3;
            end else if (rx_dv_i) begin
                if (r_state == StLen && w_len_last && w_len_bad) begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'd1;
                end else if (r_state == StCsum && rx_byte_i != r_csum) begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'd2;
                end
            end else if (w_tmo_exp) begin
                w_fail      = 1'b1;
                w_fail_code = 2'd3;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_prog       <= 1'b0;
            r_len        <= '0;
            r_len_words  <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_csum       <= '0;
            r_tmo        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_rst_n <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
            r_words      <= '0;
        end else begin
            r_prog <= prog_i;
            r_we   <= 1'b0;
            if (!w_active) begin
                if (w_prog_rise) begin
                    r_state      <= StLen;
                    r_len        <= '0;
                    r_byte_cnt   <= '0;
                    r_word       <= '0;
                    r_csum       <= '0;
                    r_tmo        <= '0;
                    r_core_rst_n <= 1'b0;
                    r_busy       <= 1'b1;
                    r_done       <= 1'b0;
                    r_err        <= 1'b0;
                    r_err_code   <= 2'd0;
                    r_words      <= '0;
                end
            end else if (w_fail) begin
                r_state      <= StErr;
                r_err        <= 1'b1;
                r_err_code   <= w_fail_code;
                r_busy       <= 1'b0;
                r_core_rst_n <= 1'b0;
            end else if (rx_dv_i) begin
                r_tmo <= '0;
                case (r_state)
                    StLen: begin
                        r_len <= w_len_next;
                        if (w_len_last) begin
                            r_byte_cnt  <= '0;
                            r_len_words <= CNT_W'(w_len_next);
                            r_state     <= StData;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                    StData: begin
                        r_csum <= r_csum + rx_byte_i;
                        if (w_word_last) begin
                            r_we       <= 1'b1;
                            r_addr     <= r_words[ADDR_W-1:0];
                            r_wdata    <= w_word_next;
                            r_word     <= '0;
                            r_byte_cnt <= '0;
                            r_words    <= w_idx_next;
                            if (w_last_word) begin
                                r_state <= StCsum;
                            end
                        end else begin
                            r_word     <= w_word_next;
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                    StCsum: begin
                        r_state      <= StDone;
                        r_done       <= 1'b1;
                        r_core_rst_n <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                    default: ;
                endcase
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    assign we_o        = r_we;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;
    assign core_rst_no = r_core_rst_n;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;
    assign words_o     = r_words;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Directed bench for iccm_boot_loader: a per-cycle vector table for a good load,
// then hand-written sequences for checksum, length, timeout, abort and reset cases.
module tb_iccm_boot_loader;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;
    logic              core_rst_no;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [1:0]        err_code_o;
    logic [ADDR_W:0]   words_o;

    iccm_boot_loader #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (1024),
        .LEN_BYTES   (2),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .prog_i      (prog),
        .rx_dv_i     (rx_dv),
        .rx_byte_i   (rx_byte),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .core_rst_no (core_rst_no),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .words_o     (words_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];

    always @(negedge clk) begin
        if (we_o) begin
            n_wr++;
            wr_addr_q.push_back(addr_o);
            wr_data_q.push_back(wdata_o);
        end
    end

    typedef struct {
        logic        prog;
        logic        dv;
        logic [7:0]  b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [63:0] pk(input logic we, input int addr, input logic [31:0] wd,
                                       input logic crn, input logic busy, input logic done,
                                       input logic err, input int code, input int words);
        return {we, 12'(addr), wd, crn, busy, done, err, 2'(code), 13'(words)};
    endfunction

    function automatic logic [63:0] outs();
        return {we_o, addr_o, wdata_o, core_rst_no, busy_o, done_o, err_o, err_code_o, words_o};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic start();
        @(negedge clk);
        prog = 1'b0;
        @(negedge clk);
        prog = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input logic [7:0] cs);
        logic [7:0] s[10];
        s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 10; i++) send(s[i]);
        send(cs);
    endtask

    initial begin
        int n0;
        int k;

        rst = 1'b1; prog = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("reset_idle", outs(), pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk); rst = 1'b0;

        // Good two-word load, one row per clock: inputs then outputs after that edge.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, pk(0, 0, 32'h0, 0, 1, 0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 1'b1, 8'h02, pk(0, 0, 32'h0, 0, 1, 0, 0, 0, 0)};
        tbl[2]  = '{1'b1, 1'b1, 8'h00, pk(0, 0, 32'h0, 0, 1, 0, 0, 0, 0)};
        tbl[3]  = '{1'b1, 1'b1, 8'h78, pk(0, 0, 32'h0, 0, 1, 0, 0, 0, 0)};
        tbl[4]  = '{1'b1, 1'b1, 8'h56, pk(0, 0, 32'h0, 0, 1, 0, 0, 0, 0)};
        tbl[5]  = '{1'b1, 1'b1, 8'h34, pk(0, 0, 32'h0, 0, 1, 0, 0, 0, 0)};
        tbl[6]  = '{1'b1, 1'b1, 8'h12, pk(1, 0, 32'h12345678, 0, 1, 0, 0, 0, 1)};
        tbl[7]  = '{1'b1, 1'b1, 8'hEF, pk(0, 0, 32'h12345678, 0, 1, 0, 0, 0, 1)};
        tbl[8]  = '{1'b1, 1'b1, 8'hBE, pk(0, 0, 32'h12345678, 0, 1, 0, 0, 0, 1)};
        tbl[9]  = '{1'b1, 1'b1, 8'hAD, pk(0, 0, 32'h12345678, 0, 1, 0, 0, 0, 1)};
        tbl[10] = '{1'b1, 1'b1, 8'hDE, pk(1, 1, 32'hDEADBEEF, 0, 1, 0, 0, 0, 2)};
        tbl[11] = '{1'b1, 1'b1, 8'h4C, pk(0, 1, 32'hDEADBEEF, 1, 0, 1, 0, 0, 2)};
        tbl[12] = '{1'b1, 1'b0, 8'h00, pk(0, 1, 32'hDEADBEEF, 1, 0, 1, 0, 0, 2)};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            prog = tbl[i].prog; rx_dv = tbl[i].dv; rx_byte = tbl[i].b;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        @(negedge clk); rx_dv = 1'b0;

        // Bytes in DONE are ignored.
        n0 = n_wr;
        send(8'h55); send(8'h66);
        chk("done_ignores_rx", 64'({done_o, err_o, busy_o, core_rst_no}), 64'(4'b1001));
        chk("done_no_write", 64'(n_wr - n0), 64'(0));

        // Bad checksum.
        n0 = n_wr;
        start();
        chk("start_clears", 64'({busy_o, core_rst_no, done_o, words_o}), 64'({3'b100, 13'd0}));
        send_stream(8'h4D);
        chk("csum_bad_writes", 64'(n_wr - n0), 64'(2));
        chk("csum_bad_state", 64'({err_o, err_code_o, core_rst_no, done_o, busy_o}),
            64'({1'b1, 2'd2, 3'b000}));

        // Zero length.
        n0 = n_wr;
        start();
        send(8'h00); send(8'h00);
        chk("len0_err", 64'({err_o, err_code_o, busy_o}), 64'({1'b1, 2'd1, 1'b0}));
        chk("len0_no_write", 64'(n_wr - n0), 64'(0));

        // Length 1025 exceeds DEPTH.
        start();
        send(8'h01); send(8'h04);
        chk("len1025_err", 64'({err_o, err_code_o, busy_o}), 64'({1'b1, 2'd1, 1'b0}));

        // Length exactly DEPTH is accepted, then prog drop aborts.
        start();
        send(8'h00); send(8'h04);
        chk("len1024_ok", 64'({err_o, busy_o}), 64'(2'b01));
        @(negedge clk); prog = 1'b0;
        @(posedge clk); #1;
        chk("len1024_abort", 64'({err_o, err_code_o, core_rst_no}), 64'({1'b1, 2'd3, 1'b0}));
        chk("len_no_write", 64'(n_wr - n0), 64'(0));

        // Timeout 100 cycles after the last strobe.
        n0 = n_wr;
        start();
        send(8'h02); send(8'h00); send(8'h78); send(8'h56); send(8'h34);
        repeat (99) @(posedge clk);
        #1;
        chk("tmo_not_yet", 64'({err_o, busy_o}), 64'(2'b01));
        @(posedge clk); #1;
        chk("tmo_err", 64'({err_o, err_code_o, busy_o}), 64'({1'b1, 2'd3, 1'b0}));
        chk("tmo_no_write", 64'(n_wr - n0), 64'(0));

        // Abort with a write pending, then a full restart.
        n0 = n_wr;
        start();
        send(8'h02); send(8'h00); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk("abort_pending_we", 64'(we_o), 64'(1));
        @(negedge clk); prog = 1'b0;
        @(posedge clk); #1;
        chk("abort_err", 64'({err_o, err_code_o, core_rst_no}), 64'({1'b1, 2'd3, 1'b0}));
        chk("abort_writes", 64'(n_wr - n0), 64'(1));
        k = wr_addr_q.size();
        start();
        send_stream(8'h4C);
        chk("restart_done", 64'({done_o, err_o, core_rst_no, words_o}), 64'({3'b101, 13'd2}));
        if (wr_addr_q.size() == k + 2) begin
            chk("restart_w0", 64'({wr_addr_q[k], wr_data_q[k]}), 64'({12'd0, 32'h12345678}));
            chk("restart_w1", 64'({wr_addr_q[k+1], wr_data_q[k+1]}), 64'({12'd1, 32'hDEADBEEF}));
        end else begin
            chk("restart_wr_count", 64'(wr_addr_q.size() - k), 64'(2));
        end

        // Asynchronous reset mid-load takes effect before any clock edge.
        start();
        send(8'h02); send(8'h00); send(8'h78);
        n0 = n_wr;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", outs(), pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        prog = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("after_rst_idle", outs(), pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk("after_rst_no_write", 64'(n_wr - n0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
